// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and constants for the debug frame serializer.
// State encoding, default sync byte and frame overhead.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_DEF  = 8'hA5;
  localparam int         FRAME_OVH = 4;

  // Saturating 8-bit increment used by the overrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dbg_frame_tx.sv
// dbg_frame_tx: latches a debug snapshot and streams it to the uart
// as sync, seq, drop count, payload and an 8-bit additive checksum.
module dbg_frame_tx
  import dbg_pkg::*;
#(
  parameter int         NUM_WORDS  = 8,
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEF,
  parameter int         DECIMATE   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              snap_req,
  input  logic [NUM_WORDS*WORD_BYTES*8-1:0] snap_data,
  output logic                              transmit,
  output logic [7:0]                        tx_byte,
  input  logic                              is_transmitting,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int         NB       = NUM_WORDS * WORD_BYTES;
  localparam int         DW       = NB * 8;
  localparam logic [7:0] LAST_IDX = 8'(FRAME_OVH + NB - 1);
  localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

  state_t state;
  state_t state_nx;

  logic [DW-1:0] shadow;
  logic [DW-1:0] snap_ord;
  logic [7:0]    idx;
  logic [7:0]    seq;
  logic [7:0]    drop_cnt;
  logic [7:0]    dec_cnt;
  logic [7:0]    checksum;
  logic [7:0]    pay_idx;
  logic [7:0]    pay_byte;
  logic [7:0]    sel_byte;
  logic          accept;
  logic          drop;
  logic          fire;
  logic          last;
  logic          latch;
  logic          step;

  assign accept  = snap_req && (dec_cnt == DEC_LAST);
  assign last    = (idx == LAST_IDX);
  assign pay_idx = idx - 8'd3;

  // Reorder words so shadow holds bytes in transmit order (MSB first).
  always_comb begin
    snap_ord = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        snap_ord[(w*WORD_BYTES + WORD_BYTES-1-b)*8 +: 8] =
          snap_data[(w*WORD_BYTES + b)*8 +: 8];
      end
    end
  end

  // Pick the payload byte addressed by the current frame index.
  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (pay_idx == 8'(i)) pay_byte = shadow[i*8 +: 8];
    end
  end

  // Frame field selection by byte index.
  always_comb begin
    sel_byte = pay_byte;
    unique case (1'b1)
      (idx == 8'd0): sel_byte = SYNC_BYTE;
      (idx == 8'd1): sel_byte = seq;
      (idx == 8'd2): sel_byte = drop_cnt;
      last:          sel_byte = checksum;
      default:       sel_byte = pay_byte;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: one handshake with the uart per byte.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_LOAD;
      ST_LOAD: if (!is_transmitting) state_nx = ST_ARM;
      ST_ARM:  state_nx = ST_WAIT;
      ST_WAIT: begin
        if (!is_transmitting) begin
          state_nx = last ? ST_IDLE : ST_LOAD;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Decoded strobes; frame_done fires as the last byte completes.
  always_comb begin
    busy       = (state != ST_IDLE);
    latch      = (state == ST_IDLE) && accept;
    fire       = (state == ST_LOAD) && !is_transmitting;
    step       = (state == ST_WAIT) && !is_transmitting;
    frame_done = step && last;
    drop       = accept && busy;
  end

  // Byte output register, pulsed transmit and checksum accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      transmit <= 1'b0;
      tx_byte  <= '0;
      checksum <= '0;
    end else begin
      transmit <= fire;
      if (latch) checksum <= '0;
      if (fire) begin
        tx_byte <= sel_byte;
        if (idx != 8'd0 && !last) checksum <= checksum + sel_byte;
      end
    end
  end

  // Snapshot latch and byte index walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      idx    <= '0;
    end else begin
      if (latch) begin
        shadow <= snap_ord;
        idx    <= '0;
      end else if (step && !last) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // Decimation, sequence number and overrun accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt  <= '0;
      seq      <= '0;
      drop_cnt <= '0;
    end else begin
      if (snap_req) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
      end
      if (frame_done) seq <= seq + 8'd1;
      if (frame_done) begin
        drop_cnt <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_dbg_frame_tx.sv
// tb_dbg_frame_tx: randomized frames against a frame-level model with a
// cycle-counting uart; checks bytes, timing, drops, decimation and reset.
module tb_dbg_frame_tx;

  localparam int         NW   = 2;
  localparam int         WB   = 2;
  localparam int         NB   = NW * WB;
  localparam int         DW   = NB * 8;
  localparam int         L    = NB + 4;
  localparam int         DEC  = 3;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          snap_req;
  logic [DW-1:0] snap_data;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic          is_transmitting;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  dbg_frame_tx #(
    .NUM_WORDS (NW),
    .WORD_BYTES(WB),
    .SYNC_BYTE (SYNC),
    .DECIMATE  (DEC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .snap_req       (snap_req),
    .snap_data      (snap_data),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .is_transmitting(is_transmitting),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // model state
  int            m_seq = 0, m_dc = 0, m_dec = 0;
  int            rx = 0, rem = 0, hold = 0, lat = 0;
  int            byte_n = 10, hold_on_accept = 0;
  bit            active = 0, busy_chk = 0, fall_chk = 0;
  bit            prev_tx = 0, prev_istx = 0, cur_valid = 0;
  bit            fix_en = 0;
  logic [DW-1:0] fix_data, m_pay;
  logic [7:0]    cur_byte, drop_snap;
  logic [7:0]    got_q[$];
  int            frames = 0;

  task automatic finish_frame();
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    logic [7:0] b;
    exp_q.push_back(SYNC);
    exp_q.push_back(8'(m_seq));
    exp_q.push_back(drop_snap);
    for (int w = 0; w < NW; w++) begin
      for (int k = WB - 1; k >= 0; k--) begin
        b = 8'((m_pay >> ((w*WB + k)*8)) & 'hFF);
        exp_q.push_back(b);
      end
    end
    sum = 8'((m_seq + int'(drop_snap)) % 256);
    for (int i = 3; i < L - 1; i++) sum = sum + exp_q[i];
    exp_q.push_back(sum);
    check("frame_len", got_q.size(), L);
    for (int i = 0; i < L; i++) begin
      if (i < got_q.size()) begin
        check($sformatf("frame%0d_byte%0d", frames, i), got_q[i], exp_q[i]);
      end
    end
    m_seq = (m_seq + 1) % 256;
    m_dc  = 0;
    frames++;
  endtask

  // One clock cycle: uart model, monitor, then request driving.
  task automatic tick(input int mode, input bit do_rst, output bit reqd);
    bit busy_now, fd_now, req, exp_fd;
    int rem_prev;
    @(negedge clk);
    is_transmitting = (hold > 0) || (rem > 0);
    rem_prev = rem;
    if (hold > 0) hold--;
    if (rem > 0) rem--;
    #1;
    if (busy_chk) begin
      check("busy_rise", busy, 1);
      busy_chk = 0;
    end
    if (fall_chk) begin
      check("busy_fall", busy, 0);
      check("idle_tx", transmit, 0);
      fall_chk = 0;
    end
    if (lat > 0) begin
      lat--;
      if (lat == 0) check("latency", transmit, 1);
    end
    busy_now = active;
    fd_now   = 0;
    if (rem_prev == 1 && cur_valid) check("tx_hold", tx_byte, cur_byte);
    if (transmit) begin
      check("tx_gap", {prev_tx, prev_istx}, 0);
      if (active) begin
        got_q.push_back(tx_byte);
        rx++;
        if (rx == 2) drop_snap = 8'(m_dc);
      end else begin
        check("spurious_tx", transmit, 0);
      end
      rem       = byte_n;
      cur_byte  = tx_byte;
      cur_valid = 1;
    end
    exp_fd = active && rx == L && !is_transmitting && !transmit;
    if (exp_fd || frame_done) check("frame_done", frame_done, exp_fd);
    if (exp_fd) begin
      finish_frame();
      active   = 0;
      fd_now   = 1;
      fall_chk = 1;
    end
    prev_tx   = transmit;
    prev_istx = is_transmitting;
    req = (mode == 1) ||
          (mode == 2 && busy_now && rx < 2) ||
          (mode == 3 && busy_now && rx >= 3) ||
          (mode == 4 && fd_now);
    if (do_rst) req = 0;
    snap_data = fix_en ? fix_data : DW'($urandom);
    snap_req  = req;
    rst       = do_rst;
    if (do_rst) begin
      active = 0; m_seq = 0; m_dc = 0; m_dec = 0; lat = 0;
      busy_chk = 0; rx = 0; cur_valid = 0; fall_chk = 1;
      got_q.delete();
    end else if (req) begin
      if (m_dec == DEC - 1) begin
        m_dec = 0;
        if (busy_now) begin
          m_dc = (m_dc == 255) ? 255 : m_dc + 1;
        end else begin
          active   = 1;
          rx       = 0;
          got_q.delete();
          m_pay    = snap_data;
          hold     = hold_on_accept;
          busy_chk = 1;
          lat      = (hold == 0 && rem == 0) ? 2 : 0;
        end
      end else begin
        m_dec++;
      end
    end
    reqd = req;
  endtask

  task automatic start_frame(input int h, input int n);
    int guard;
    bit r;
    byte_n = n;
    hold_on_accept = h;
    guard = 0;
    while (!active && guard < 50) begin
      tick(1, 0, r);
      guard++;
    end
    hold_on_accept = 0;
    check("accept_timeout", active, 1);
  endtask

  task automatic run_frame(input int n_early, input int n_late,
                           input bit fd_drop, input int h, input int n);
    int guard, cnt;
    bit r;
    repeat (2) tick(0, 0, r);
    start_frame(h, n);
    cnt = 0; guard = 0;
    while (cnt < n_early && active && guard < 5000) begin
      tick(2, 0, r); cnt += int'(r); guard++;
    end
    cnt = 0; guard = 0;
    while (cnt < n_late && active && guard < 5000) begin
      tick(3, 0, r); cnt += int'(r); guard++;
    end
    guard = 0;
    while (active && guard < 5000) begin
      tick(fd_drop ? 4 : 0, 0, r); guard++;
    end
    check("frame_timeout", active, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit r;
    int guard;
    rst = 1'b1;
    snap_req = 1'b0;
    snap_data = '0;
    is_transmitting = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_transmit", transmit, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    tick(0, 0, r);

    // known payload, then same payload with seq 1
    fix_en = 1;
    fix_data = 32'h1234_ABCD;
    run_frame(0, 0, 0, 0, 10);
    run_frame(0, 0, 0, 0, 10);
    fix_en = 0;

    // three overruns early in the frame
    run_frame(3 * DEC, 0, 0, 20, 10);
    // late overruns and one in the frame_done cycle
    run_frame(0, 2 * DEC, 1, 0, 6);
    run_frame(0, 0, 0, 0, 3);

    // random frames
    for (int k = 0; k < 16; k++) begin
      run_frame($urandom_range(0, 7), $urandom_range(0, 5),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40),
                $urandom_range(1, 12));
    end

    // drop counter saturation
    run_frame(300 * DEC + 6, 0, 0, 300 * DEC + 60, 3);
    // uart busy for 50 cycles at the request
    run_frame(0, 0, 0, 50, 4);

    // reset in the middle of the payload
    repeat (2) tick(0, 0, r);
    start_frame(0, 8);
    guard = 0;
    while (rx < 5 && active && guard < 2000) begin
      tick(0, 0, r); guard++;
    end
    check("reset_reach", rx, 5);
    tick(0, 1, r);
    repeat (30) tick(0, 0, r);
    run_frame(0, 0, 0, 0, 5);
    run_frame(1, 1, 1, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
